// File: rtl/core_ifu_pkg.sv
// Shared widths, reset vector and FSM encoding for the instruction fetch unit.
package core_ifu_pkg;

   localparam int          CPU_PC_SIZE    = 64;
   localparam int          CPU_INSTR_SIZE = 32;
   localparam logic [63:0] CPU_RESET_PC   = 64'h0000_0000_8000_0000;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } ifu_state_t;

endpackage

// File: rtl/core_ifu_fifo.sv
// Instruction buffer: head is visible the cycle after a push, and push/pop may share a cycle.
// Flush beats push; pop or push against an empty or full buffer is ignored.
module core_ifu_fifo #(
   parameter int WIDTH = 96,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         din,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic [WIDTH-1:0]         head
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      end
   end

   // Storage needs no reset; validity is tracked by count alone.
   always_ff @(posedge clk) begin
      if (do_push && !flush && !rst) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/core_ifu.sv
// Fetch unit: one outstanding imem request, responses buffered; first instr visible 3 cycles after reset release.
// Stops issuing while the buffer is full; redirect flushes the buffer and drops the in-flight response.
module core_ifu
   import core_ifu_pkg::*;
#(
   parameter int              PC_W      = CPU_PC_SIZE,
   parameter int              INSTR_W   = CPU_INSTR_SIZE,
   parameter logic [PC_W-1:0] RESET_PC  = PC_W'(CPU_RESET_PC),
   parameter int              BUF_DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req_valid,
   input  logic               imem_req_ready,
   output logic [PC_W-1:0]    imem_req_addr,
   input  logic               imem_resp_valid,
   input  logic [INSTR_W-1:0] imem_resp_data,
   input  logic               redirect_i,
   input  logic [PC_W-1:0]    redirect_pc_i,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PC_W-1:0]    pc_o,
   output logic [INSTR_W-1:0] instr_o,
   output logic [PC_W-1:0]    snpc_o
);

   localparam int              CW         = $clog2(BUF_DEPTH) + 1;
   localparam logic [CW-1:0]   DEPTH_C    = CW'(BUF_DEPTH);
   localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);
   localparam logic [PC_W-1:0] PC_STEP    = PC_W'(4);

   ifu_state_t                 state;
   logic [PC_W-1:0]            fetch_pc;
   logic [PC_W-1:0]            req_pc;
   logic                       drop;
   logic                       req_hs;
   logic                       push;
   logic                       pop;
   logic                       full;
   logic                       empty;
   logic [CW-1:0]              count;
   logic [CW-1:0]              post_count;
   logic [PC_W+INSTR_W-1:0]    head;
   logic [PC_W-1:0]            redirect_tgt;

   assign imem_req_valid = (state == S_REQ);
   assign imem_req_addr  = fetch_pc;
   assign req_hs         = imem_req_valid && imem_req_ready;
   assign push           = (state == S_WAIT) && imem_resp_valid && !drop && !redirect_i;
   assign pop            = !empty && out_ready;
   assign post_count     = count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
   assign redirect_tgt   = redirect_pc_i & ALIGN_MASK;

   assign out_valid = !empty;
   assign pc_o      = head[PC_W+INSTR_W-1:INSTR_W];
   assign instr_o   = head[INSTR_W-1:0];
   assign snpc_o    = pc_o + PC_STEP;

   core_ifu_fifo #(
      .WIDTH (PC_W + INSTR_W),
      .DEPTH (BUF_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (redirect_i),
      .din   ({req_pc, imem_resp_data}),
      .full  (full),
      .empty (empty),
      .count (count),
      .head  (head)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         fetch_pc <= RESET_PC & ALIGN_MASK;
         req_pc   <= '0;
         drop     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (redirect_i) begin
                  fetch_pc <= redirect_tgt;
                  state    <= S_REQ;
               end else if (!full) begin
                  state <= S_REQ;
               end
            end
            S_REQ: begin
               if (req_hs) begin
                  req_pc <= fetch_pc;
                  state  <= S_WAIT;
               end
               // A redirect racing the handshake still lets the request go out; its reply is dropped.
               if (redirect_i) begin
                  fetch_pc <= redirect_tgt;
                  drop     <= req_hs;
               end else if (req_hs) begin
                  fetch_pc <= fetch_pc + PC_STEP;
               end
            end
            S_WAIT: begin
               if (redirect_i) fetch_pc <= redirect_tgt;
               if (imem_resp_valid) begin
                  drop <= 1'b0;
                  if (redirect_i || post_count < DEPTH_C) state <= S_REQ;
                  else                                    state <= S_IDLE;
               end else if (redirect_i) begin
                  drop <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/core_ifu.md
Name: core_ifu

Overview:
Instruction fetch unit. It is the stage directly upstream of the IF/ID pipeline register in the RV64IM core. It owns the fetch PC, issues word-aligned fetches to instruction memory over a valid/ready request plus response-valid interface, and buffers returned instructions in a small FIFO. It presents {pc, instr, snpc} to IF/ID with a valid/ready handshake, and honours redirects from branch/jump resolution by flushing the FIFO and discarding stale in-flight responses.

Parameters:
RESET_PC, 64'h0000_0000_8000_0000, fetch address after reset
BUF_DEPTH, 2, instruction buffer entries (power of two, at least 2)
PC_W, `CPU_PC_SIZE (64), PC width
INSTR_W, `CPU_INSTR_SIZE (32), instruction width

Ports:
clk  in  1  core clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request this cycle
imem_req_addr  out  PC_W  fetch address; bits [1:0] are always 0
imem_resp_valid  in  1  response for the single outstanding request
imem_resp_data  in  INSTR_W  fetched instruction
redirect_i  in  1  control-flow redirect (branch/jump/trap)
redirect_pc_i  in  PC_W  redirect target
out_valid  out  1  buffer head valid toward IF/ID
out_ready  in  1  IF/ID can accept (low = stall)
pc_o  out  PC_W  head PC
instr_o  out  INSTR_W  head instruction
snpc_o  out  PC_W  head PC + 4

Behaviour:
- Reset (rst=1 at an edge):
  - fetch_pc <= RESET_PC; state <= S_IDLE; FIFO emptied; drop flag cleared.
  - Outputs: out_valid=0, imem_req_valid=0, pc_o=0, instr_o=0, snpc_o=4. When the FIFO is empty, pc_o and instr_o are driven 0.
  - Reset mid-transaction abandons any outstanding request. A response arriving after reset is ignored unless the FSM is in S_WAIT.
- FSM states:
  - S_IDLE: imem_req_valid=0. Go to S_REQ when FIFO count < BUF_DEPTH and redirect_i=0.
  - S_REQ: imem_req_valid=1, imem_req_addr=fetch_pc.
    - On valid&ready: req_pc <= fetch_pc; fetch_pc <= fetch_pc+4; go to S_WAIT.
    - Address is held stable while valid and not ready. The only exception is redirect.
  - S_WAIT: imem_req_valid=0; single outstanding request.
    - On imem_resp_valid: push {req_pc, data} unless the drop flag is set; clear the drop flag.
    - Next state is S_REQ if post-push count < BUF_DEPTH, else S_IDLE.
- Issue is allowed only when count < BUF_DEPTH, so a push can never overflow. A push and a pop in the same cycle are both legal.
- Output side:
  - out_valid = FIFO not empty.
  - pc_o/instr_o = head entry; snpc_o = pc_o + 4 (64-bit, wraps modulo 2^64).
  - Pop on out_valid & out_ready. Outputs are stable while out_valid=1 and out_ready=0.
- Redirect (highest priority):
  - FIFO flushed the same edge; out_valid=0 the next cycle.
  - fetch_pc <= {redirect_pc_i[63:2], 2'b00}.
  - In S_REQ without handshake: stay in S_REQ; the address changes next cycle.
  - In S_REQ with handshake the same cycle: go to S_WAIT with drop=1; fetch_pc takes the redirect target, not +4.
  - In S_WAIT with no response: drop=1.
  - In S_WAIT with a response the same cycle: the response is discarded; go to S_REQ.
  - In S_IDLE: go to S_REQ.
  - A pop in the redirect cycle still completes; the downstream consumer is responsible for squashing it.
- Latency: with memory always ready and a one-cycle response:
  - rst deasserted at edge 0 → S_REQ at cycle 1.
  - Response at cycle 2 → out_valid at cycle 3.
  - Steady throughput: 1 instruction per 2 cycles (single outstanding request).
- fetch_pc wraps modulo 2^64. There is no misalignment trap; low bits are forced to zero.

Decomposition:
- defines.v: CPU_PC_SIZE, CPU_INSTR_SIZE, CPU_RESET_PC, and the IFU state encodings (S_IDLE=2'd0, S_REQ=2'd1, S_WAIT=2'd2).
- Sub-module core_ifu_fifo, a synchronous FIFO of width PC_W+INSTR_W and depth BUF_DEPTH:
  - Ports: push, pop, flush, full, empty, count, head.
  - Flush takes priority over push.
- Architectural registers use the existing Reg primitive where a plain enable-register fits.

Test Plan:
- Reset release, mem always ready, 1-cycle response → requests 0x80000000, 0x80000004, 0x80000008. Out stream has pc_o=0x80000000, instr_o=resp data, snpc_o=0x80000004, with out_valid first high at cycle 3.
- out_ready=0 for 10 cycles → FIFO fills to 2 entries, FSM parks in S_IDLE, no new request, head stable. Release → entries drain in order and fetch resumes at 0x80000008.
- Redirect to 0x80001002 while in S_WAIT → next response is discarded. Next request address is 0x80001000, FIFO is empty the cycle after redirect, and the first output pc is 0x80001000.
- Redirect in the same cycle as a req handshake, and separately in the same cycle as imem_resp_valid → no stale instruction is ever pushed, and the next address equals the redirect target.
- imem_req_ready held low 5 cycles in S_REQ → imem_req_addr is stable and no fetch_pc advance. fetch_pc=0xFFFF_FFFF_FFFF_FFFC → snpc_o=0 and the next request address is 0.
- rst asserted in S_WAIT with a response pending → after reset, state is S_IDLE with FIFO empty. A late response is ignored, and fetch restarts at RESET_PC.
